// File: rtl/pulse_rate_meter.sv
// Counts rising edges of an asynchronous pulse over a fixed gate window of clk
// cycles and latches the saturated count for a downstream display controller.
module pulse_rate_meter #(
    parameter logic [31:0] GATE_CYCLES = 32'd100000000,
    parameter logic [15:0] MAX_COUNT   = 16'd9999
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pulse_in,
    input  logic        enable,
    input  logic        hold,
    output logic [15:0] displayed_number,
    output logic        overflow,
    output logic        update
);

    localparam logic [31:0] GATE_LAST = GATE_CYCLES - 32'd1;

    // [0] = s1, [1] = s2 (synchronized), [2] = s3 (edge history)
    logic [2:0]  sync_reg;

    logic [31:0] gate_reg, gate_next;
    logic [15:0] acc_reg, acc_next;
    logic        sat_reg, sat_next;
    logic [15:0] disp_reg, disp_next;
    logic        ovf_reg, ovf_next;
    logic        upd_reg, upd_next;

    logic        edge_det;
    logic        terminal;
    logic        acc_full;
    logic [15:0] candidate;

    assign edge_det  = sync_reg[1] & ~sync_reg[2];
    assign terminal  = (gate_reg == GATE_LAST);
    assign acc_full  = (acc_reg >= MAX_COUNT);
    assign candidate = (edge_det && !acc_full) ? acc_reg + 16'd1 : acc_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= 3'b000;
        end else begin
            sync_reg <= {sync_reg[1:0], pulse_in};
        end
    end

    always_comb begin
        gate_next = gate_reg;
        acc_next  = acc_reg;
        sat_next  = sat_reg;
        disp_next = disp_reg;
        ovf_next  = ovf_reg;
        upd_next  = 1'b0;

        if (!enable) begin
            gate_next = 32'd0;
            acc_next  = 16'd0;
            sat_next  = 1'b0;
        end else if (terminal) begin
            // An edge landing on the terminal cycle still belongs to the closing window.
            gate_next = 32'd0;
            acc_next  = 16'd0;
            sat_next  = 1'b0;
            if (!hold) begin
                disp_next = candidate;
                ovf_next  = sat_reg | (edge_det & acc_full);
                upd_next  = 1'b1;
            end
        end else begin
            gate_next = gate_reg + 32'd1;
            acc_next  = candidate;
            if (edge_det && acc_full) begin
                sat_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_reg <= 32'd0;
            acc_reg  <= 16'd0;
            sat_reg  <= 1'b0;
            disp_reg <= 16'd0;
            ovf_reg  <= 1'b0;
            upd_reg  <= 1'b0;
        end else begin
            gate_reg <= gate_next;
            acc_reg  <= acc_next;
            sat_reg  <= sat_next;
            disp_reg <= disp_next;
            ovf_reg  <= ovf_next;
            upd_reg  <= upd_next;
        end
    end

    assign displayed_number = disp_reg;
    assign overflow         = ovf_reg;
    assign update           = upd_reg;

endmodule

// File: tb/tb_pulse_rate_meter.sv
// Directed bench for pulse_rate_meter with a 100-cycle gate: one instance at the
// default ceiling and one with a ceiling of 20 share the same stimulus.
module tb_pulse_rate_meter;

    logic        clk;
    logic        rst_n;
    logic        pulse_in;
    logic        enable;
    logic        hold;
    logic [15:0] disp;
    logic        ovf;
    logic        upd;
    logic [15:0] disp_sat;
    logic        ovf_sat;
    logic        upd_sat;

    int n_cmp;
    int n_bad;

    pulse_rate_meter #(.GATE_CYCLES(32'd100), .MAX_COUNT(16'd9999)) dut (
        .clk(clk), .rst_n(rst_n), .pulse_in(pulse_in), .enable(enable), .hold(hold),
        .displayed_number(disp), .overflow(ovf), .update(upd)
    );

    pulse_rate_meter #(.GATE_CYCLES(32'd100), .MAX_COUNT(16'd20)) dut_sat (
        .clk(clk), .rst_n(rst_n), .pulse_in(pulse_in), .enable(enable), .hold(hold),
        .displayed_number(disp_sat), .overflow(ovf_sat), .update(upd_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int n_edges;
        int period;
        bit term_edge;
        bit hold_v;
        bit exp_upd;
        int exp_disp;
        bit exp_ovf;
        int exp_disp_sat;
        bit exp_ovf_sat;
    } win_t;

    win_t tbl [12];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    // Pulse starts at window step 2 (edge lands 3 cycles later); a terminal
    // edge is raised at step 97 so it is detected on the window's last cycle.
    function automatic logic lvl(input int t, input int n, input int p, input bit term);
        if (term && t >= 97) return 1'b1;
        if (t < 2) return 1'b0;
        if ((t - 2) / p >= n) return 1'b0;
        return ((t - 2) % p) < (p / 2);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_window(input int n, input int p, input bit term, input bit hold_v,
                              output int st, output int st_sat);
        st = 0;
        st_sat = 0;
        for (int t = 0; t < 100; t++) begin
            pulse_in = lvl(t, n, p, term);
            hold = hold_v;
            step();
            if (t < 99) begin
                st += int'(upd);
                st_sat += int'(upd_sat);
            end
        end
    endtask

    initial begin
        int st;
        int st_sat;
        n_cmp = 0;
        n_bad = 0;

        //  n   per term hold upd disp ovf  sdisp sovf
        tbl[0]  = '{0,  2,  0, 0, 1, 0,  0, 0,  0};
        tbl[1]  = '{10, 10, 0, 0, 1, 10, 0, 10, 0};
        tbl[2]  = '{10, 10, 0, 0, 1, 10, 0, 10, 0};
        tbl[3]  = '{6,  10, 1, 0, 1, 7,  0, 7,  0};
        tbl[4]  = '{3,  10, 0, 0, 1, 3,  0, 3,  0};
        tbl[5]  = '{30, 2,  0, 0, 1, 30, 0, 20, 1};
        tbl[6]  = '{5,  2,  0, 0, 1, 5,  0, 5,  0};
        tbl[7]  = '{12, 4,  0, 1, 0, 5,  0, 5,  0};
        tbl[8]  = '{15, 4,  0, 1, 0, 5,  0, 5,  0};
        tbl[9]  = '{9,  4,  0, 0, 1, 9,  0, 9,  0};
        tbl[10] = '{20, 2,  1, 0, 1, 21, 0, 20, 1};
        tbl[11] = '{20, 2,  0, 0, 1, 20, 0, 20, 0};

        rst_n = 1'b0;
        pulse_in = 1'b0;
        enable = 1'b0;
        hold = 1'b0;
        repeat (3) step();
        check("reset_disp", int'(disp), 0);
        check("reset_ovf", int'(ovf), 0);
        check("reset_upd", int'(upd), 0);
        rst_n = 1'b1;
        repeat (3) step();

        enable = 1'b1;
        for (int i = 0; i < 12; i++) begin
            run_window(tbl[i].n_edges, tbl[i].period, tbl[i].term_edge, tbl[i].hold_v, st, st_sat);
            check($sformatf("win%0d_upd", i), int'(upd), int'(tbl[i].exp_upd));
            check($sformatf("win%0d_disp", i), int'(disp), tbl[i].exp_disp);
            check($sformatf("win%0d_ovf", i), int'(ovf), int'(tbl[i].exp_ovf));
            check($sformatf("win%0d_sat_upd", i), int'(upd_sat), int'(tbl[i].exp_upd));
            check($sformatf("win%0d_sat_disp", i), int'(disp_sat), tbl[i].exp_disp_sat);
            check($sformatf("win%0d_sat_ovf", i), int'(ovf_sat), int'(tbl[i].exp_ovf_sat));
            check($sformatf("win%0d_stray_upd", i), st + st_sat, 0);
        end

        // Enable abort: 4 edges, drop enable at gate=60, pulse while disabled, re-raise 10 later.
        st = 0;
        for (int t = 0; t < 70; t++) begin
            enable = (t < 60);
            pulse_in = (t < 60) ? lvl(t, 4, 10, 1'b0) : ((t >= 62) && (t < 65));
            hold = 1'b0;
            step();
            st += int'(upd) + int'(upd_sat);
        end
        check("abort_no_upd", st, 0);
        check("abort_disp_kept", int'(disp), 20);
        enable = 1'b1;
        run_window(3, 10, 1'b0, 1'b0, st, st_sat);
        check("reenable_stray_upd", st + st_sat, 0);
        check("reenable_upd", int'(upd), 1);
        check("reenable_disp", int'(disp), 3);
        check("reenable_sat_disp", int'(disp_sat), 3);

        // Asynchronous reset mid-window with 37 edges accumulated.
        st = 0;
        for (int t = 0; t < 80; t++) begin
            pulse_in = lvl(t, 37, 2, 1'b0);
            step();
            st += int'(upd) + int'(upd_sat);
        end
        check("midrst_pre_stray", st, 0);
        rst_n = 1'b0;
        #1;
        check("midrst_disp", int'(disp), 0);
        check("midrst_ovf", int'(ovf), 0);
        check("midrst_upd", int'(upd), 0);
        check("midrst_sat_disp", int'(disp_sat), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_window(0, 2, 1'b0, 1'b0, st, st_sat);
        check("postrst_stray_upd", st + st_sat, 0);
        check("postrst_upd", int'(upd), 1);
        check("postrst_disp", int'(disp), 0);
        step();
        check("upd_single_cycle", int'(upd), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
